// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding the UART transceiver: buffers bus-side bytes and
// issues them one at a time over the tx_data/tx_wr/tx_done handshake.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    input  logic                  flush,
    input  logic [DEPTH_LOG2:0]   threshold,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  thre_irq,
    output logic                  tx_idle,
    output logic [7:0]            tx_data,
    output logic                  tx_wr,
    input  logic                  tx_done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LEVEL_MAX = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [0:0]            state;
    logic [0:0]            state_next;
    logic                  do_write;
    logic                  do_pop;
    logic [DEPTH_LOG2:0]   level_next;

    // flush cancels both a same-cycle write and a same-cycle pop, but never
    // aborts the byte already in flight
    always_comb begin
        do_write   = wr_en && !full && !flush;
        do_pop     = 1'b0;
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (level != '0 && !flush) begin
                    do_pop     = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (tx_done) begin
                    do_pop     = (level != '0) && !flush;
                    state_next = do_pop ? ST_BUSY : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        level_next = level;
        if (flush) begin
            level_next = '0;
        end else if (do_write && !do_pop) begin
            level_next = level + LEVEL_ONE;
        end else if (!do_write && do_pop) begin
            level_next = level - LEVEL_ONE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_write) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
            thre_irq <= 1'b0;
            tx_wr    <= 1'b0;
            tx_data  <= 8'h00;
            state    <= ST_IDLE;
            tx_idle  <= 1'b1;
        end else begin
            if (do_write) begin
                wptr <= wptr + PTR_ONE;
            end

            if (flush) begin
                rptr <= wptr;
            end else if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end

            if (do_pop) begin
                tx_data <= mem[rptr];
            end
            tx_wr <= do_pop;

            if (flush) begin
                overflow <= 1'b0;
            end else if (wr_en && full) begin
                overflow <= 1'b1;
            end

            // only a pop can move level downward across the threshold;
            // a concurrent write keeps level flat, so no crossing occurs
            thre_irq <= do_pop && (level > threshold) && (level_next <= threshold);

            level   <= level_next;
            full    <= (level_next == LEVEL_MAX);
            state   <= state_next;
            tx_idle <= (state_next == ST_IDLE) && (level_next == '0);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH_LOG2 = 4).
module tb_uart_tx_fifo;

    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       flush;
    logic [4:0] threshold;
    logic       full;
    logic [4:0] level;
    logic       overflow;
    logic       thre_irq;
    logic       tx_idle;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_done;

    int checks;
    int errors;
    int tx_wr_count;
    int irq_count;
    int tx_before;
    logic [7:0] sent[$];
    logic [7:0] exp_q[$];

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .flush     (flush),
        .threshold (threshold),
        .full      (full),
        .level     (level),
        .overflow  (overflow),
        .thre_irq  (thre_irq),
        .tx_idle   (tx_idle),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_done   (tx_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Record every issued byte and irq pulse, sampled mid-cycle
    always @(negedge sys_clk) begin
        if (tx_wr === 1'b1) begin
            tx_wr_count++;
            sent.push_back(tx_data);
        end
        if (thre_irq === 1'b1) begin
            irq_count++;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] d,
                                 input logic fl, input logic done);
        wr_en   = we;
        wr_data = d;
        flush   = fl;
        tx_done = done;
        tick();
        wr_en   = 1'b0;
        wr_data = 8'h00;
        flush   = 1'b0;
        tx_done = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sentAt(input int i);
        return (i < sent.size()) ? sent[i] : 8'hxx;
    endfunction

    // Transceiver model: FSM is BUSY on entry; each tx_done pops the next byte
    task automatic serveBytes(input int n, input int start_lvl);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
            checkOutput("serve_tx_wr", tx_wr, (i < n - 1));
            checkOutput("serve_level", level, (i < n - 1) ? (start_lvl - 1 - i) : 0);
        end
    endtask

    initial begin
        sys_rst   = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        flush     = 1'b0;
        tx_done   = 1'b0;
        threshold = 5'd16;

        $display("[TB] reset values");
        repeat (3) tick();
        checkOutput("rst_level", level, 0);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_thre_irq", thre_irq, 0);
        checkOutput("rst_tx_wr", tx_wr, 0);
        checkOutput("rst_tx_data", tx_data, 8'h00);
        checkOutput("rst_tx_idle", tx_idle, 1);
        sys_rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] single byte");
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("single_level_w", level, 1);
        checkOutput("single_tx_wr_w", tx_wr, 0);
        checkOutput("single_idle_w", tx_idle, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("single_tx_wr", tx_wr, 1);
        checkOutput("single_tx_data", tx_data, 8'hA5);
        checkOutput("single_level_pop", level, 0);
        checkOutput("single_idle_pop", tx_idle, 0);
        checkOutput("single_irq_hi_thr", thre_irq, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("single_tx_wr_pulse", tx_wr, 0);
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("single_idle_wait", tx_idle, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("single_idle_done", tx_idle, 1);
        checkOutput("single_sent_n", sent.size(), 1);
        checkOutput("single_sent_0", sentAt(0), 8'hA5);
        checkOutput("single_irq_count", irq_count, 0);

        $display("[TB] burst, full, overflow, threshold");
        sent.delete();
        irq_count = 0;
        threshold = 5'd4;
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, 8'(k), 1'b0, 1'b0);
        end
        checkOutput("burst_level16", level, 15);
        checkOutput("burst_full16", full, 0);
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        checkOutput("burst_level17", level, 16);
        checkOutput("burst_full17", full, 1);
        checkOutput("burst_ovf17", overflow, 0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("ovf_level", level, 16);
        checkOutput("ovf_full", full, 1);
        checkOutput("ovf_flag", overflow, 1);
        serveBytes(17, 16);
        checkOutput("burst_idle", tx_idle, 1);
        checkOutput("burst_full_end", full, 0);
        checkOutput("burst_sent_n", sent.size(), 17);
        for (int k = 0; k < 17; k++) begin
            checkOutput("burst_order", sentAt(k), 8'(k + 1));
        end
        checkOutput("burst_irq_count", irq_count, 1);

        $display("[TB] wrap-around");
        sent.delete();
        threshold = 5'd16;
        for (int g = 0; g < 10; g++) begin
            for (int j = 0; j < 4; j++) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                applyStimulus(1'b1, b, 1'b0, 1'b0);
            end
            checkOutput("wrap_level3", level, 3);
            serveBytes(4, 3);
        end
        checkOutput("wrap_sent_n", sent.size(), 40);
        for (int k = 0; k < 40; k++) begin
            checkOutput("wrap_order", sentAt(k), exp_q[k]);
        end
        checkOutput("wrap_idle", tx_idle, 1);

        $display("[TB] flush mid-transfer");
        sent.delete();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 8'(8'h61 + k), 1'b0, 1'b0);
        end
        checkOutput("flush_pre_level", level, 4);
        checkOutput("flush_pre_ovf", overflow, 1);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        checkOutput("flush_level", level, 0);
        checkOutput("flush_ovf", overflow, 0);
        checkOutput("flush_tx_wr", tx_wr, 0);
        checkOutput("flush_idle_busy", tx_idle, 0);
        tx_before = tx_wr_count;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("flush_done_tx_wr", tx_wr, 0);
        checkOutput("flush_done_idle", tx_idle, 1);
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("flush_no_issue", tx_wr_count - tx_before, 0);
        checkOutput("flush_sent_n", sent.size(), 1);
        checkOutput("flush_sent_0", sentAt(0), 8'h61);

        $display("[TB] async reset");
        sent.delete();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 8'(8'h71 + k), 1'b0, 1'b0);
        end
        checkOutput("arst_pre_level", level, 3);
        checkOutput("arst_pre_data", tx_data, 8'h71);
        #3 sys_rst = 1'b1;
        #1;
        checkOutput("arst_level", level, 0);
        checkOutput("arst_idle", tx_idle, 1);
        checkOutput("arst_tx_data", tx_data, 8'h00);
        checkOutput("arst_full", full, 0);
        tick();
        tick();
        sys_rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        checkOutput("arst_w_level", level, 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("arst_tx_wr", tx_wr, 1);
        checkOutput("arst_tx_data2", tx_data, 8'h3C);
        serveBytes(1, 1);
        checkOutput("arst_idle_end", tx_idle, 1);
        checkOutput("arst_sent_n", sent.size(), 2);
        checkOutput("arst_sent_last", sentAt(1), 8'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
